fetch_stage: RTL

Instruction fetch stage of the 16-bit pipeline. It holds the PC and drives the instruction memory controller's address combinationally. It captures the returned instruction word in the same cycle and registers {pc, pc+1, instruction, valid} into the IF/ID pipeline register consumed by decode. It handles stall, branch redirect and the structural hazard when data access owns the shared instruction memory.

---
 rtl/fetch_stage_pkg.sv | 33 +++
 rtl/fetch_pc_reg.sv | 52 +++++
 rtl/fetch_stage.sv | 117 +++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage.
//
// Holds the default register width, the bubble instruction word and the
// per-cycle action decode. The PC register and the IF/ID register both use
// that decode, so they always agree on who wins in a given cycle.
package fetch_stage_pkg;

  localparam int          REG_WIDTH     = 16;
  localparam logic [15:0] NOP_INST_WORD = 16'h0800;

  // What the fetch stage does on the next rising edge.
  typedef enum logic [1:0] {
    ACT_REDIRECT,  // branch taken: load target, squash IF/ID
    ACT_HOLD,      // hazard stall: freeze everything
    ACT_BUBBLE,    // memory busy with data access: hold PC, insert bubble
    ACT_FETCH      // normal fetch: capture word, advance PC
  } fetch_act_e;

  // A redirect beats a stall, and a stall beats a busy memory. A branch must
  // never be lost to a hazard, because the instruction in flight is already
  // on the wrong path.
  function automatic fetch_act_e fetch_action(input logic branch_en,
                                              input logic stall,
                                              input logic imem_busy);
    fetch_act_e act;
    if (branch_en)      act = ACT_REDIRECT;
    else if (stall)     act = ACT_HOLD;
    else if (imem_busy) act = ACT_BUBBLE;
    else                act = ACT_FETCH;
    return act;
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register for the fetch stage.
//
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   branch_en            redirect request
//   branch_target        redirect PC
//   stall                hazard hold
//   imem_busy            instruction memory taken by a data access
//   pc                   current PC (drives the memory address)
//   pc_plus1             pc + 1, modulo 2^WIDTH
module fetch_pc_reg
  import fetch_stage_pkg::*;
#(
  parameter int               WIDTH    = REG_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             branch_en,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             stall,
  input  logic             imem_busy,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus1
);

  logic [WIDTH-1:0] pc_d, pc_q;
  logic [WIDTH-1:0] pc_inc;
  fetch_act_e       act;

  // The increment wraps naturally at the register width.
  assign pc_inc = pc_q + WIDTH'(1);
  assign act    = fetch_action(branch_en, stall, imem_busy);

  always_comb begin
    pc_d = pc_q;
    unique case (act)
      ACT_REDIRECT: pc_d = branch_target;
      ACT_FETCH:    pc_d = pc_inc;
      default:      pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_q <= RESET_PC;
    else      pc_q <= pc_d;
  end

  assign pc       = pc_q;
  assign pc_plus1 = pc_inc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage of the 16-bit pipeline.
//
// The stage presents the PC to the instruction memory combinationally. It
// captures the same-cycle instruction word into the IF/ID register together
// with its PC, PC+1 and a valid flag. It also counts accepted fetches.
//
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   imem_addr            address to instruction memory (always = pc)
//   imem_data            instruction word returned in the same cycle
//   imem_busy            memory owned by a data access this cycle
//   stall                hazard unit holds IF and IF/ID
//   branch_en            redirect request
//   branch_target        redirect PC
//   if_pc                PC of the instruction in IF/ID
//   if_pc_plus1          if_pc + 1
//   if_inst              instruction in IF/ID (NOP_INST when a bubble)
//   if_valid             IF/ID holds a real fetched instruction
//   fetch_cnt            number of accepted fetches, wrapping
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int               WIDTH    = REG_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] NOP_INST = NOP_INST_WORD
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_data,
  input  logic             imem_busy,
  input  logic             stall,
  input  logic             branch_en,
  input  logic [WIDTH-1:0] branch_target,
  output logic [WIDTH-1:0] if_pc,
  output logic [WIDTH-1:0] if_pc_plus1,
  output logic [WIDTH-1:0] if_inst,
  output logic             if_valid,
  output logic [WIDTH-1:0] fetch_cnt
);

  logic [WIDTH-1:0] pc, pc_plus1;
  fetch_act_e       act;

  logic [WIDTH-1:0] if_pc_d, if_pc_q;
  logic [WIDTH-1:0] if_pc_plus1_d, if_pc_plus1_q;
  logic [WIDTH-1:0] if_inst_d, if_inst_q;
  logic             if_valid_d, if_valid_q;
  logic [WIDTH-1:0] fetch_cnt_d, fetch_cnt_q;

  fetch_pc_reg #(
    .WIDTH    (WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .rst           (rst),
    .branch_en     (branch_en),
    .branch_target (branch_target),
    .stall         (stall),
    .imem_busy     (imem_busy),
    .pc            (pc),
    .pc_plus1      (pc_plus1)
  );

  assign imem_addr = pc;
  assign act       = fetch_action(branch_en, stall, imem_busy);

  // A redirect and a busy memory both leave a bubble, which is the same
  // zeroed, invalid NOP pattern used at reset. Decode can then treat every
  // invalid slot identically.
  always_comb begin
    if_pc_d       = if_pc_q;
    if_pc_plus1_d = if_pc_plus1_q;
    if_inst_d     = if_inst_q;
    if_valid_d    = if_valid_q;
    fetch_cnt_d   = fetch_cnt_q;
    unique case (act)
      ACT_REDIRECT, ACT_BUBBLE: begin
        if_pc_d       = '0;
        if_pc_plus1_d = '0;
        if_inst_d     = NOP_INST;
        if_valid_d    = 1'b0;
      end
      ACT_FETCH: begin
        if_pc_d       = pc;
        if_pc_plus1_d = pc_plus1;
        if_inst_d     = imem_data;
        if_valid_d    = 1'b1;
        fetch_cnt_d   = fetch_cnt_q + WIDTH'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_pc_q       <= '0;
      if_pc_plus1_q <= '0;
      if_inst_q     <= NOP_INST;
      if_valid_q    <= 1'b0;
      fetch_cnt_q   <= '0;
    end else begin
      if_pc_q       <= if_pc_d;
      if_pc_plus1_q <= if_pc_plus1_d;
      if_inst_q     <= if_inst_d;
      if_valid_q    <= if_valid_d;
      fetch_cnt_q   <= fetch_cnt_d;
    end
  end

  assign if_pc       = if_pc_q;
  assign if_pc_plus1 = if_pc_plus1_q;
  assign if_inst     = if_inst_q;
  assign if_valid    = if_valid_q;
  assign fetch_cnt   = fetch_cnt_q;

endmodule
